// File: rtl/sequential_divider.sv
// Sequential restoring divider: one quotient bit per clock, start/ready handshake, divide-by-zero flag.
// Optional macro DIVIDER_SIGNED_EN adds two's-complement operands with truncation toward zero.
module sequential_divider #(
    parameter int Word_Length = 8
) (
    input  logic                   clk,
    input  logic                   reset_Input,
    input  logic                   start,
    input  logic [Word_Length-1:0] Dividend,
    input  logic [Word_Length-1:0] Divisor,
    output logic [Word_Length-1:0] Quotient,
    output logic [Word_Length-1:0] Remainder,
    output logic                   Ready_output,
    output logic                   Done_output,
    output logic                   Div_By_Zero,
    output logic [1:0]             State_output
);
    localparam int W  = Word_Length;
    localparam int CW = $clog2(W);

    // Handshake: start is sampled only while Ready_output=1 (IDLE); results are valid
    // on Quotient/Remainder/Div_By_Zero during the single cycle Done_output=1.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOAD  = 2'b01,
        SHIFT = 2'b10,
        DONE  = 2'b11
    } state_t;

    state_t          state;
    logic [W-1:0]    q_work;
    logic [W:0]      r_work;
    logic [W-1:0]    d_reg;
    logic [CW-1:0]   counter;

    logic [W:0]      r_shift;
    logic [W:0]      r_trial;
    logic [W:0]      r_next;
    logic [W-1:0]    q_next;
    logic [W-1:0]    q_final;
    logic [W-1:0]    r_final;
    logic [W-1:0]    dividend_mag;
    logic [W-1:0]    divisor_mag;

`ifdef DIVIDER_SIGNED_EN
    logic            neg_q;
    logic            neg_r;
`endif

    always_comb begin
        r_shift = {r_work[W-1:0], q_work[W-1]};
        r_trial = r_shift - {1'b0, d_reg};
        if (!r_trial[W]) begin
            r_next = r_trial;
            q_next = {q_work[W-2:0], 1'b1};
        end else begin
            r_next = r_shift;
            q_next = {q_work[W-2:0], 1'b0};
        end
`ifdef DIVIDER_SIGNED_EN
        dividend_mag = Dividend[W-1] ? (~Dividend + 1'b1) : Dividend;
        divisor_mag  = Divisor[W-1]  ? (~Divisor + 1'b1)  : Divisor;
        q_final      = neg_q ? (~q_next + 1'b1) : q_next;
        r_final      = neg_r ? (~r_next[W-1:0] + 1'b1) : r_next[W-1:0];
`else
        dividend_mag = Dividend;
        divisor_mag  = Divisor;
        q_final      = q_next;
        r_final      = r_next[W-1:0];
`endif
    end

    // Results are written on the edge entering DONE so they are valid alongside Done_output.
    always_ff @(posedge clk or negedge reset_Input) begin
        if (!reset_Input) begin
            state       <= IDLE;
            q_work      <= '0;
            r_work      <= '0;
            d_reg       <= '0;
            counter     <= '0;
            Quotient    <= '0;
            Remainder   <= '0;
            Div_By_Zero <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) state <= LOAD;
                end
                LOAD: begin
                    q_work      <= dividend_mag;
                    r_work      <= '0;
                    d_reg       <= divisor_mag;
                    counter     <= '0;
                    Div_By_Zero <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
                    neg_q       <= Dividend[W-1] ^ Divisor[W-1];
                    neg_r       <= Dividend[W-1];
`endif
                    if (Divisor == '0) begin
                        Quotient    <= '1;
                        Remainder   <= Dividend;
                        Div_By_Zero <= 1'b1;
                        state       <= DONE;
                    end else begin
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    q_work  <= q_next;
                    r_work  <= r_next;
                    counter <= counter + 1'b1;
                    if (counter == CW'(W - 1)) begin
                        Quotient  <= q_final;
                        Remainder <= r_final;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign Ready_output = (state == IDLE);
    assign Done_output  = (state == DONE);
    assign State_output = state;

endmodule

// File: tb/tb_sequential_divider.sv
// Randomized scoreboard bench for sequential_divider: driver pushes expected results, monitor pops on Done.
module tb_sequential_divider;
    localparam int W = 8;

    logic          clk = 1'b0;
    logic          reset_Input = 1'b1;
    logic          start = 1'b0;
    logic [W-1:0]  Dividend = '0;
    logic [W-1:0]  Divisor = '0;
    logic [W-1:0]  Quotient;
    logic [W-1:0]  Remainder;
    logic          Ready_output;
    logic          Done_output;
    logic          Div_By_Zero;
    logic [1:0]    State_output;

    sequential_divider #(.Word_Length(W)) dut (
        .clk          (clk),
        .reset_Input  (reset_Input),
        .start        (start),
        .Dividend     (Dividend),
        .Divisor      (Divisor),
        .Quotient     (Quotient),
        .Remainder    (Remainder),
        .Ready_output (Ready_output),
        .Done_output  (Done_output),
        .Div_By_Zero  (Div_By_Zero),
        .State_output (State_output)
    );

    // Clock / reset
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Scoreboard: {dbz, quotient, remainder}, issue cycle, expected latency
    logic [2*W:0] exp_q[$];
    int           iss_q[$];
    int           lat_q[$];
    int           n_checks = 0;
    int           n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] q;
        logic [W-1:0] r;
        int sa;
        int sb;
        int sq;
        int sr;
        if (b == '0) return {1'b1, {W{1'b1}}, a};
`ifdef DIVIDER_SIGNED_EN
        sa = $signed(a);
        sb = $signed(b);
`else
        sa = int'(a);
        sb = int'(b);
`endif
        sq = sa / sb;
        sr = sa % sb;
        q  = sq[W-1:0];
        r  = sr[W-1:0];
        return {1'b0, q, r};
    endfunction

    // Driver
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
        int t = 0;
        while (!Ready_output && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("ready_wait", {31'd0, Ready_output}, 32'd1);
        Dividend = a;
        Divisor  = b;
        start    = 1'b1;
        if (push) begin
            exp_q.push_back(model(a, b));
            iss_q.push_back(cyc);
            lat_q.push_back((b == '0) ? 2 : W + 2);
        end
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        Dividend = W'($urandom);
        Divisor  = W'($urandom);
    endtask

    // Monitor
    initial begin
        logic [2*W:0] e;
        int iss;
        int lat;
        forever begin
            @(negedge clk);
            if (Done_output === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got Done=1 expected no pending result (cycle %0d)", cyc);
                end else begin
                    e   = exp_q.pop_front();
                    iss = iss_q.pop_front();
                    lat = lat_q.pop_front();
                    check("quotient", 32'(Quotient), 32'(e[2*W-1:W]));
                    check("remainder", 32'(Remainder), 32'(e[W-1:0]));
                    check("div_by_zero", {31'd0, Div_By_Zero}, {31'd0, e[2*W]});
                    check("done_cycle", cyc, iss + lat);
                end
                @(negedge clk);
                check("ready_after_done", {31'd0, Ready_output}, 32'd1);
            end
        end
    end

    // Stimulus
    initial begin
        int t;
        logic [W-1:0] a;
        logic [W-1:0] b;
        #2 reset_Input = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_state", 32'(State_output), 32'd0);
        check("rst_quotient", 32'(Quotient), 32'd0);
        check("rst_remainder", 32'(Remainder), 32'd0);
        check("rst_ready", {31'd0, Ready_output}, 32'd1);
        check("rst_done", {31'd0, Done_output}, 32'd0);
        check("rst_dbz", {31'd0, Div_By_Zero}, 32'd0);
        reset_Input = 1'b1;
        @(negedge clk);

        issue(8'd100, 8'd7, 1'b1);
        issue(8'd255, 8'd1, 1'b1);
        issue(8'd3, 8'd200, 1'b1);
        issue(8'd5, 8'd0, 1'b1);
        check("dbz_no_shift", 32'(State_output), 32'd3);
        issue(8'd9, 8'd3, 1'b1);
`ifdef DIVIDER_SIGNED_EN
        issue(8'h9C, 8'd7, 1'b1);
        issue(8'h80, 8'hFF, 1'b1);
        issue(8'd100, 8'hF9, 1'b1);
`endif

        // start during SHIFT must be ignored
        issue(8'd100, 8'd7, 1'b1);
        repeat (2) @(negedge clk);
        check("in_shift", 32'(State_output), 32'd2);
        Dividend = 8'd1;
        Divisor  = 8'd1;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;

        // Reset mid-operation aborts without a Done pulse
        issue(8'd50, 8'd3, 1'b1);
        repeat (3) @(negedge clk);
        reset_Input = 1'b0;
        #1;
        check("abort_state", 32'(State_output), 32'd0);
        check("abort_quotient", 32'(Quotient), 32'd0);
        check("abort_remainder", 32'(Remainder), 32'd0);
        check("abort_ready", {31'd0, Ready_output}, 32'd1);
        exp_q.delete();
        iss_q.delete();
        lat_q.delete();
        repeat (3) @(negedge clk);
        reset_Input = 1'b1;
        repeat (15) @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            a = W'($urandom_range(0, 255));
            case ($urandom_range(0, 9))
                0:       b = '0;
                1, 2, 3: b = W'($urandom_range(1, 15));
                default: b = W'($urandom_range(1, 255));
            endcase
            issue(a, b, 1'b1);
        end

        t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
